// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner:
//   - kp_state_e       : scanner FSM states
//   - KEY_MAP          : hex code of each key, indexed [row][col]
//   - onehot_low_valid : true when exactly one row line is pulled low
//   - row_index        : index of the single low row line
//   - col_drive        : active-low one-hot column drive for a column index
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_e;

    // Row 3 carries the '*' and '#' keys, encoded as E and F.
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Several simultaneous rows are ambiguous, so only a single low row counts.
    function automatic logic onehot_low_valid(input logic [3:0] rows);
        logic ok;
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] drv;
        case (idx)
            2'd0:    drv = 4'b1110;
            2'd1:    drv = 4'b1101;
            2'd2:    drv = 4'b1011;
            2'd3:    drv = 4'b0111;
            default: drv = 4'b1110;
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for asynchronous level inputs.
// Parameters: W (width), RST_VAL (value loaded on reset).
// Ports:
//   clk   : system clock
//   rst_i : synchronous active-high reset
//   d     : asynchronous input
//   q     : synchronized output (two clk cycles of delay)
// -----------------------------------------------------------------------------
module sync2 #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Metastability stage followed by the stable stage.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad column by column, debounces presses
// and releases, encodes the key to a hex nibble and shifts it into data_o.
// Parameters: DW (data_o width, multiple of 4), SCAN_DIV (clk cycles per
// column), DEBOUNCE_CNT (stable samples needed for press/release).
// Ports:
//   clk         : system clock
//   rst_i       : synchronous active-high reset
//   row_i       : keypad rows, active-low, asynchronous
//   clr_i       : synchronous clear of data_o
//   col_o       : column drive, active-low, exactly one bit low
//   key_valid_o : one-cycle pulse per accepted press
//   key_code_o  : code of the last accepted key
//   data_o      : shift register of accepted codes, newest in [3:0]
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DW           = 32,
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic [3:0]    row_i,
    input  logic          clr_i,
    output logic [3:0]    col_o,
    output logic          key_valid_o,
    output logic [3:0]    key_code_o,
    output logic [DW-1:0] data_o
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [PW-1:0] PERIOD_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PERIOD_ONE  = PW'(1);
    localparam logic [PW-1:0] PERIOD_ZERO = PW'(0);
    localparam logic [CW-1:0] DEB_TARGET  = CW'(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
    localparam bit            DEB_ONE     = (DEBOUNCE_CNT == 1);

    logic [3:0]    rs_s;
    logic          strobe_s;
    logic [PW-1:0] period_r;

    kp_state_e     state_r;
    kp_state_e     state_s;
    logic [1:0]    col_idx_r;
    logic [1:0]    col_idx_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [CW-1:0] cnt_inc_s;
    logic [3:0]    cand_r;
    logic [3:0]    cand_s;
    logic          accept_s;
    logic [3:0]    code_s;

    logic [3:0]    col_r;
    logic          key_valid_r;
    logic [3:0]    key_code_r;
    logic [DW-1:0] data_r;

    sync2 #(
        .W       (4),
        .RST_VAL (4'b1111)
    ) u_row_sync (
        .clk   (clk),
        .rst_i (rst_i),
        .d     (row_i),
        .q     (rs_s)
    );

    // The strobe lands at the end of each column period so rows have settled.
    assign strobe_s  = (period_r == PERIOD_LAST);
    assign cnt_inc_s = cnt_r + CNT_ONE;
    // At any accept the synchronized rows equal the candidate pattern.
    assign code_s    = KEY_MAP[row_index(rs_s)][col_idx_r];

    // Free-running column period counter.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            period_r <= PERIOD_ZERO;
        end else if (strobe_s) begin
            period_r <= PERIOD_ZERO;
        end else begin
            period_r <= period_r + PERIOD_ONE;
        end
    end

    // Next-state logic: scan, debounce a press, then wait for a stable release.
    always_comb begin
        state_s   = state_r;
        col_idx_s = col_idx_r;
        cnt_s     = cnt_r;
        cand_s    = cand_r;
        accept_s  = 1'b0;
        if (strobe_s) begin
            case (state_r)
                SCAN: begin
                    if (onehot_low_valid(rs_s)) begin
                        cand_s = rs_s;
                        if (DEB_ONE) begin
                            accept_s = 1'b1;
                            state_s  = HELD;
                            cnt_s    = CNT_ZERO;
                        end else begin
                            state_s  = DEBOUNCE;
                            cnt_s    = CNT_ONE;
                        end
                    end else begin
                        col_idx_s = col_idx_r + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (rs_s == cand_r) begin
                        if (cnt_inc_s == DEB_TARGET) begin
                            accept_s = 1'b1;
                            state_s  = HELD;
                            cnt_s    = CNT_ZERO;
                        end else begin
                            cnt_s    = cnt_inc_s;
                        end
                    end else begin
                        state_s   = SCAN;
                        cnt_s     = CNT_ZERO;
                        col_idx_s = col_idx_r + 2'd1;
                    end
                end
                HELD: begin
                    // Any non-idle sample restarts the release count.
                    if (rs_s == 4'b1111) begin
                        if (cnt_inc_s == DEB_TARGET) begin
                            state_s   = SCAN;
                            cnt_s     = CNT_ZERO;
                            col_idx_s = col_idx_r + 2'd1;
                        end else begin
                            cnt_s     = cnt_inc_s;
                        end
                    end else begin
                        cnt_s = CNT_ZERO;
                    end
                end
                default: begin
                    state_s = SCAN;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM state, column index, counters and candidate registers.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_r   <= SCAN;
            col_idx_r <= 2'd0;
            col_r     <= 4'b1110;
            cnt_r     <= CNT_ZERO;
            cand_r    <= 4'b1111;
        end else begin
            state_r   <= state_s;
            col_idx_r <= col_idx_s;
            col_r     <= col_drive(col_idx_s);
            cnt_r     <= cnt_s;
            cand_r    <= cand_s;
        end
    end

    // Accepted-key outputs: pulse, held code and shift register with clear.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            key_valid_r <= 1'b0;
            key_code_r  <= 4'h0;
            data_r      <= {DW{1'b0}};
        end else begin
            key_valid_r <= accept_s;
            if (accept_s) begin
                key_code_r <= code_s;
            end else begin
                key_code_r <= key_code_r;
            end
            if (accept_s && clr_i) begin
                data_r <= {{(DW-4){1'b0}}, code_s};
            end else if (accept_s) begin
                data_r <= {data_r[DW-5:0], code_s};
            end else if (clr_i) begin
                data_r <= {DW{1'b0}};
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign col_o       = col_r;
    assign key_valid_o = key_valid_r;
    assign key_code_o  = key_code_r;
    assign data_o      = data_r;

endmodule
